smoke_mc_inc_bfm: RTL

// - Multi-channel, parametrised successor to the single-method "inc" smoke BFM.
// - Sits between the tblink_rpc invoke glue and the testbench clock domain.
// - Requests (channel tag + operand) are buffered in a FIFO, executed with a configurable

---
 rtl/smoke_mc_bfm_pkg.sv | 51 +++++
 rtl/smoke_mc_bfm_fifo.sv | 50 +++++
 rtl/smoke_mc_inc_bfm.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/smoke_mc_bfm_pkg.sv
// Shared declarations for the multi-channel inc BFM: FSM encodings, RPC identifiers, inc arithmetic.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package smoke_mc_bfm_pkg;

  // Sequencer states. The plain logic constants below are what the RTL compares against, so
  // older tools and waveform filters that expect raw 2-bit codes keep working.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_RESP = RESP;

  // Identifiers shared with the RPC side, which registers the interface type by name.
  localparam int    METHOD_ID_INC   = 0;
  localparam string TARGET_IFC_NAME = "target_mc";

  // Widest operand inc_op handles; callers zero-extend narrower operands.
  localparam int DATA_WIDTH_MAX = 64;

  // Increment the low 'width' bits of data. Returns {ovf, result}: ovf marks an all-ones
  // operand, whose result is either all-ones (saturate) or zero (wrap).
  function automatic logic [DATA_WIDTH_MAX:0] inc_op(
    input logic [DATA_WIDTH_MAX-1:0] data,
    input int                        width,
    input logic                      saturate
  );
    logic [DATA_WIDTH_MAX-1:0] mask;
    logic [DATA_WIDTH_MAX-1:0] res;
    logic                      ovf;
    if (width >= DATA_WIDTH_MAX) begin
      mask = '1;
    end else begin
      mask = (DATA_WIDTH_MAX'(1) << width) - DATA_WIDTH_MAX'(1);
    end
    ovf = ((data & mask) == mask);
    if (!ovf) begin
      res = (data + DATA_WIDTH_MAX'(1)) & mask;
    end else if (saturate) begin
      res = mask;
    end else begin
      res = '0;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/smoke_mc_bfm_fifo.sv
// Synchronous FIFO holding {chan, data} request entries for the inc BFM.
// Latency: an entry pushed at edge N is visible at the head after edge N (no bypass).
// Backpressure: full_o blocks further pushes; pop while empty and push while full are ignored.
// Ports: clk_i/rst_i (sync, active-high); push_i/wdata_i write side; pop_i/rdata_o read side
//        (rdata_o is the current head); full_o, empty_o, count_o status.
module smoke_mc_bfm_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  // One extra pointer bit separates "full" (MSBs differ) from "empty" (pointers equal).
  logic [AW:0]       wptr_q, rptr_q;
  logic              do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/smoke_mc_inc_bfm.sv
// Multi-channel inc BFM: queued requests return operand+1 (wrap or saturate) with per-channel call counters.
// Latency: request accepted in cycle T into an idle, empty block -> rsp_valid in cycle T+2+LATENCY.
// Backpressure: req_ready = !FIFO full; a response holds its outputs until rsp_ready, one idle cycle between requests.
// Ports: clock/reset (sync, active-high); req_valid/req_ready/req_chan/req_data request in;
//        rsp_valid/rsp_ready/rsp_chan/rsp_data/rsp_ovf/rsp_err response out; busy;
//        call_count packs one CNT_WIDTH counter per channel, channel 0 in the LSBs.
module smoke_mc_inc_bfm
  import smoke_mc_bfm_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  N_CHANNELS = 4,
  parameter int  FIFO_DEPTH = 4,
  parameter int  LATENCY    = 2,
  parameter int  SATURATE   = 0,
  parameter int  CNT_WIDTH  = 16,
  localparam int CHAN_W     = $clog2(N_CHANNELS + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [CHAN_W-1:0]                req_chan,
  input  logic [DATA_WIDTH-1:0]            req_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [CHAN_W-1:0]                rsp_chan,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             rsp_ovf,
  output logic                             rsp_err,
  output logic                             busy,
  output logic [N_CHANNELS*CNT_WIDTH-1:0]  call_count
);

  localparam int         ENT_W    = CHAN_W + DATA_WIDTH;
  localparam int         FCNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENT_W-1:0]      fifo_head;
  logic [FCNT_W-1:0]     fifo_count;
  logic [CHAN_W-1:0]     head_chan;
  logic [DATA_WIDTH-1:0] head_data;

  logic [1:0]            state_q, state_d;
  logic [3:0]            lat_q, lat_d;
  logic [CHAN_W-1:0]     op_chan_q, op_chan_d;
  logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
  logic [CHAN_W-1:0]     rsp_chan_q, rsp_chan_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_ovf_q, rsp_ovf_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [CNT_WIDTH-1:0]  cnt_q [N_CHANNELS];
  logic [CNT_WIDTH-1:0]  cnt_d [N_CHANNELS];
  logic                  rsp_fire;

  // Returns {err, ovf, result}. A bad channel echoes the operand untouched.
  function automatic logic [DATA_WIDTH+1:0] execute(
    input logic [CHAN_W-1:0]     chan,
    input logic [DATA_WIDTH-1:0] data
  );
    logic [DATA_WIDTH_MAX:0] r;
    r = inc_op(DATA_WIDTH_MAX'(data), DATA_WIDTH, SATURATE != 0);
    if (32'(chan) >= 32'(N_CHANNELS)) begin
      execute = {1'b1, 1'b0, data};
    end else begin
      execute = {1'b0, r[DATA_WIDTH_MAX], DATA_WIDTH'(r)};
    end
  endfunction

  assign fifo_push              = req_valid && req_ready;
  assign {head_chan, head_data} = fifo_head;

  smoke_mc_bfm_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i ({req_chan, req_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    op_chan_d  = op_chan_q;
    op_data_d  = op_data_q;
    rsp_chan_d = rsp_chan_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          op_chan_d = head_chan;
          op_data_d = head_data;
          if (LATENCY == 0) begin
            // Zero latency: compute straight from the FIFO head so RESP follows the pop.
            state_d                            = ST_RESP;
            rsp_chan_d                         = head_chan;
            {rsp_err_d, rsp_ovf_d, rsp_data_d} = execute(head_chan, head_data);
          end else begin
            state_d = ST_EXEC;
            lat_d   = LAT_LOAD;
          end
        end
      end
      ST_EXEC: begin
        if (lat_q == 4'd1) begin
          state_d                            = ST_RESP;
          rsp_chan_d                         = op_chan_q;
          {rsp_err_d, rsp_ovf_d, rsp_data_d} = execute(op_chan_q, op_data_q);
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_RESP: begin
        // Returning to IDLE rather than popping here leaves one bubble per request.
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_fire = (state_q == ST_RESP) && rsp_ready;

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (rsp_fire && !rsp_err_q && (32'(rsp_chan_q) == c)) begin
        cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      op_chan_q  <= '0;
      op_data_q  <= '0;
      rsp_chan_q <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      for (int c = 0; c < N_CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      op_chan_q  <= op_chan_d;
      op_data_q  <= op_data_d;
      rsp_chan_q <= rsp_chan_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
      for (int c = 0; c < N_CHANNELS; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  always_comb begin
    call_count = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      call_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c];
    end
  end

  assign req_ready = !fifo_full;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_chan  = rsp_chan_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
